// File: rtl/starfield_ctrl_pkg.sv
// Shared timing defaults, key indices and types for the starfield controller.
package starfield_ctrl_pkg;

  localparam int unsigned H_DISPLAY_DEF  = 256;
  localparam int unsigned H_FRONT_DEF    = 7;
  localparam int unsigned H_SYNC_DEF     = 23;
  localparam int unsigned H_BACK_DEF     = 23;
  localparam int unsigned V_DISPLAY_DEF  = 240;
  localparam int unsigned V_BOTTOM_DEF   = 14;
  localparam int unsigned V_SYNC_DEF     = 3;
  localparam int unsigned V_TOP_DEF      = 5;
  localparam int unsigned DEB_CYCLES_DEF = 16;
  localparam int unsigned SPEED_INIT_DEF = 3;

  // Bit positions of the user keys on the keys bus.
  typedef enum logic [1:0] {
    KEY_UP    = 2'd0,
    KEY_DN    = 2'd1,
    KEY_PAUSE = 2'd2,
    KEY_DIR   = 2'd3
  } key_idx_t;

  typedef logic [2:0] speed_t;

  // Last counter value of a raster axis (H_MAX / V_MAX).
  function automatic int unsigned h_max(input int unsigned disp, input int unsigned front,
                                        input int unsigned sync, input int unsigned back);
    return disp + front + sync + back - 1;
  endfunction

  function automatic int unsigned v_max(input int unsigned disp, input int unsigned bottom,
                                        input int unsigned sync, input int unsigned top);
    return disp + bottom + sync + top - 1;
  endfunction

endpackage

// File: rtl/starfield_ctrl_if.sv
// Key, raster, run-state and pixel signals between the controller and its neighbours.
interface starfield_ctrl_if;
  import starfield_ctrl_pkg::*;

  logic [3:0] keys;
  logic [2:0] rgb_in;
  logic [8:0] hpos;
  logic [8:0] vpos;
  logic       display_on;
  logic       frame_tick;
  logic       step_en;
  logic       dir;
  speed_t     speed;
  logic       paused;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb;

  modport master (
    input  keys, rgb_in,
    output hpos, vpos, display_on, frame_tick, step_en, dir, speed, paused,
           hsync, vsync, rgb
  );

  modport slave (
    output keys, rgb_in,
    input  hpos, vpos, display_on, frame_tick, step_en, dir, speed, paused,
           hsync, vsync, rgb
  );
endinterface

// File: rtl/key_debounce.sv
// One key: 2-FF synchronizer, stability counter, registered press pulse.
module key_debounce #(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic press
);
  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          s1, s2;
  logic          level, level_d;
  logic [CW-1:0] cnt;

  // Bring the raw key into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= key;
      s2 <= s1;
    end
  end

  // Accept a new level only after DEB_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= 1'b0;
      cnt   <= '0;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEB_CYCLES - 1)) begin
      level <= s2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // One-cycle pulse on the debounced rising edge; releases are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_d <= 1'b0;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= level & ~level_d;
    end
  end
endmodule

// File: rtl/starfield_ctrl.sv
// Raster timing, key handling, run state and frame-rate stepping for the starfield.
module starfield_ctrl
  import starfield_ctrl_pkg::*;
#(
  parameter int unsigned H_DISPLAY  = H_DISPLAY_DEF,
  parameter int unsigned H_FRONT    = H_FRONT_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BACK     = H_BACK_DEF,
  parameter int unsigned V_DISPLAY  = V_DISPLAY_DEF,
  parameter int unsigned V_BOTTOM   = V_BOTTOM_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_TOP      = V_TOP_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned SPEED_INIT = SPEED_INIT_DEF
) (
  input logic       clk,
  input logic       reset,
  starfield_ctrl_if.master bus
);
  localparam logic [8:0] HMAX     = 9'(h_max(H_DISPLAY, H_FRONT, H_SYNC, H_BACK));
  localparam logic [8:0] VMAX     = 9'(v_max(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP));
  localparam logic [8:0] HS_FIRST = 9'(H_DISPLAY + H_FRONT);
  localparam logic [8:0] HS_LAST  = 9'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [8:0] VS_FIRST = 9'(V_DISPLAY + V_BOTTOM);
  localparam logic [8:0] VS_LAST  = 9'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

  logic [8:0] hpos_q, vpos_q;
  logic       display_on, hsync_dec, vsync_dec, frame_tick, step_en;
  logic [3:0] press;
  speed_t     speed_q;
  logic       dir_q, paused_q;
  logic [2:0] fdiv;
  logic       up, dn;

  // Pixel/line counters; the line advances on the pixel wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos_q <= '0;
      vpos_q <= '0;
    end else if (hpos_q == HMAX) begin
      hpos_q <= '0;
      vpos_q <= (vpos_q == VMAX) ? '0 : vpos_q + 9'd1;
    end else begin
      hpos_q <= hpos_q + 9'd1;
    end
  end

  // Decodes from the registered counters.
  always_comb begin
    display_on = (hpos_q < 9'(H_DISPLAY)) && (vpos_q < 9'(V_DISPLAY));
    hsync_dec  = (hpos_q >= HS_FIRST) && (hpos_q <= HS_LAST);
    vsync_dec  = (vpos_q >= VS_FIRST) && (vpos_q <= VS_LAST);
    frame_tick = (hpos_q == '0) && (vpos_q == 9'(V_DISPLAY));
    step_en    = frame_tick && !paused_q && (fdiv == '0);
  end

  // Single register stage for all pins keeps sync and pixel aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.hsync <= 1'b1;
      bus.vsync <= 1'b1;
      bus.rgb   <= '0;
    end else begin
      bus.hsync <= ~hsync_dec;
      bus.vsync <= ~vsync_dec;
      bus.rgb   <= display_on ? bus.rgb_in : '0;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .reset (reset),
      .key   (bus.keys[g]),
      .press (press[g])
    );
  end

  assign up = press[KEY_UP];
  assign dn = press[KEY_DN];

  // Run state driven by key press events; up+down together cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      speed_q  <= speed_t'(SPEED_INIT);
      dir_q    <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      if (up && !dn && speed_q != '1) begin
        speed_q <= speed_q + speed_t'(1);
      end else if (dn && !up && speed_q != '0) begin
        speed_q <= speed_q - speed_t'(1);
      end
      if (press[KEY_PAUSE]) paused_q <= ~paused_q;
      if (press[KEY_DIR])   dir_q    <= ~dir_q;
    end
  end

  // Frame divider: one step every 8-speed unpaused frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fdiv <= '0;
    end else if (frame_tick && !paused_q) begin
      fdiv <= (fdiv == '0) ? 3'd7 - speed_q : fdiv - 3'd1;
    end
  end

  assign bus.hpos       = hpos_q;
  assign bus.vpos       = vpos_q;
  assign bus.display_on = display_on;
  assign bus.frame_tick = frame_tick;
  assign bus.step_en    = step_en;
  assign bus.speed      = speed_q;
  assign bus.dir        = dir_q;
  assign bus.paused     = paused_q;
endmodule
